data_memory_unit: RTL and testbench
===================================

# data_memory_unit

Data memory for the pipelined processor's Memory stage. It consumes the scalar and vector ALU results, write data and write enables produced by Execute. It returns scalar and vector read data to the Memory-Writeback pipeline register. Scalar accesses complete in one cycle. A 256-bit vector access is serialised into eight 32-bit word transfers by a small FSM, and the block raises a stall toward the hazard unit until the transfer is done.

## Interface
- N, 24, scalar data/address width
- DEPTH, 256, number of 32-bit storage words; must be a power of two and ≥ 8
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- MemWrite_scalar  in  1  scalar store enable
- A_scalar  in  N  scalar word address
- WD_scalar  in  N  scalar store data
- RD_scalar  out  N  scalar load data (combinational)
- MemRead_vector  in  1  vector load request
- MemWrite_vector  in  1  vector store request
- A_vector  in  N  vector base word address
- WD_vector  in  256  vector store data; lane k = bits [32k+31:32k]
- RD_vector  out  256  vector load data (registered)
- MemStall  out  1  stall request to hazard unit (freeze F/D/E/M)
- vDone  out  1  one-cycle pulse when a vector access completes

## Operation
- Storage is DEPTH × 32-bit words, word-addressed. The index is the address modulo DEPTH, using the low log2(DEPTH) bits. Storage is not cleared by reset.
- Scalar load: RD_scalar = mem[A_scalar idx][N-1:0], combinational, in every state.
- Scalar store: writes {(32-N)'b0, WD_scalar} at the edge. It commits only when MemStall=0 (state IDLE without a vector request, or DONE).
- Vector base: A_vector idx with bits [2:0] forced to 0. Word k is at (base+k) mod DEPTH.
- The FSM has three states.
  - IDLE: Transitions to XFER if MemWrite_vector or MemRead_vector is high. At that edge it captures the op, base and WD_vector, and sets count=0. If both requests are high, the write takes priority.
  - XFER: Each cycle it handles word count. A read loads mem[base+count] into RD_vector lane count. A write stores captured lane count to mem[base+count]. count increments each cycle; after count=7 the FSM goes to DONE.
  - DONE: vDone=1. Any vector request held on the inputs is ignored. The FSM returns to IDLE unconditionally.
- MemStall = (IDLE and any vector request) or XFER. It is 0 in DONE and in IDLE without a request.
- Inputs changing during XFER have no effect, because all operands are captured.
- RD_vector lanes are updated only during a vector read. Between reads, RD_vector holds the last vector read.

## Timing
- Reset values: state IDLE, count 0, RD_vector 0, MemStall 0, vDone 0. RD_scalar follows storage.
- Vector access timeline:
  - t0: IDLE with request, MemStall=1.
  - t1..t8: XFER for words 0..7, MemStall=1.
  - t9: DONE, MemStall=0, vDone=1, RD_vector fully valid.
  - The pipeline advances at the end of t9, so the MW register samples the complete RD_vector.
- Total vector latency: 10 cycles, of which 9 are stalled. Scalar access latency: 0 cycles (read) and 1 edge (write).
- Back-to-back vector requests: a second request can start no earlier than the cycle after DONE.
- Wrap-around: base = DEPTH-8 is aligned and does not wrap. The index wraps modulo DEPTH only for addresses ≥ DEPTH.
- Reset mid-XFER: the FSM goes to IDLE and the counters and outputs return to their reset values. Words already stored by a partial vector write remain, and the remaining words are untouched.
- Scalar store requested in the same cycle as a vector request: it is held off by MemStall and commits in the DONE cycle.

## Test plan
- Scalar store 0x123456 to addr 5, then load addr 5 -> RD_scalar=0x123456 in the same cycle as the address change. The upper 8 bits of the stored word are 0.
- Preload words 16..23 with 0x1000+k via scalar stores. Vector load at A_vector=19 -> base 16. MemStall is high for exactly 9 cycles, vDone pulses once in cycle 10, and RD_vector lane k=0x1000+k.
- Vector store of lane k=0xA0+k at base 8, then scalar loads of addr 8..15 -> 0xA0..0xA7. Words 7 and 16 are unchanged.
- MemRead_vector and MemWrite_vector both high -> a store is performed and RD_vector keeps its previous value.
- Vector request held high through DONE -> only one transfer and one vDone pulse. A new request in the next cycle restarts with MemStall=1 immediately.
- Vector store starting at base 0; rst asserted low at XFER count=3 -> the next cycle has MemStall=0, vDone=0 and RD_vector=0. Words 0..2 are updated, words 3..7 keep their old values.

Source files
------------

// File: rtl/data_memory_unit.sv
// Memory-stage data memory: single-cycle scalar access plus a 256-bit vector
// access serialised into eight word transfers, with a stall held until done.
module data_memory_unit #(
    parameter int N     = 24,
    parameter int DEPTH = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           MemWrite_scalar,
    input  logic [N-1:0]   A_scalar,
    input  logic [N-1:0]   WD_scalar,
    output logic [N-1:0]   RD_scalar,
    input  logic           MemRead_vector,
    input  logic           MemWrite_vector,
    input  logic [N-1:0]   A_vector,
    input  logic [255:0]   WD_vector,
    output logic [255:0]   RD_vector,
    output logic           MemStall,
    output logic           vDone
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [2:0]     r_count;
    logic           r_op_write;
    logic [AW-1:0]  r_base;
    logic [255:0]   r_wd;
    logic [255:0]   r_rd_vector;
    logic [31:0]    r_mem [DEPTH];

    logic           w_vec_req;
    logic [AW-1:0]  w_scalar_idx;
    logic [AW-1:0]  w_vec_base;
    logic [AW-1:0]  w_xfer_idx;
    logic [31:0]    w_scalar_word;
    logic           w_mem_we;
    logic [AW-1:0]  w_mem_addr;
    logic [31:0]    w_mem_wdata;
    logic           w_unused;

    assign w_vec_req     = MemRead_vector | MemWrite_vector;
    assign w_scalar_idx  = A_scalar[AW-1:0];
    assign w_vec_base    = {A_vector[AW-1:3], 3'b000};
    assign w_xfer_idx    = r_base + {{(AW-3){1'b0}}, r_count};
    assign w_scalar_word = r_mem[w_scalar_idx];
    assign w_unused      = ^{A_scalar[N-1:AW], A_vector[N-1:AW], A_vector[2:0], w_scalar_word[31:N]};

    assign RD_scalar = w_scalar_word[N-1:0];
    assign RD_vector = r_rd_vector;
    assign MemStall  = ((r_state == S_IDLE) && w_vec_req) || (r_state == S_XFER);
    assign vDone     = (r_state == S_DONE);

    // Next-state logic for the vector transfer sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_vec_req) begin
                    w_next_state = S_XFER;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_XFER: begin
                if (r_count == 3'd7) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_XFER;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register, operand capture and vector read-data assembly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_count     <= 3'd0;
            r_op_write  <= 1'b0;
            r_base      <= '0;
            r_wd        <= '0;
            r_rd_vector <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (w_vec_req) begin
                        // write wins when both requests are raised together
                        r_op_write <= MemWrite_vector;
                        r_base     <= w_vec_base;
                        r_wd       <= WD_vector;
                        r_count    <= 3'd0;
                    end
                end
                S_XFER: begin
                    r_count <= r_count + 3'd1;
                    if (!r_op_write) begin
                        r_rd_vector[{r_count, 5'b00000} +: 32] <= r_mem[w_xfer_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // Single write port: vector words during a store transfer, else an unstalled scalar store.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = w_scalar_idx;
        w_mem_wdata = {{(32-N){1'b0}}, WD_scalar};
        if ((r_state == S_XFER) && r_op_write) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = w_xfer_idx;
            w_mem_wdata = r_wd[{r_count, 5'b00000} +: 32];
        end else if (MemWrite_scalar && !MemStall) begin
            w_mem_we = 1'b1;
        end else begin
            w_mem_we = 1'b0;
        end
    end

    // Storage array; contents survive reset, but no write lands in a reset cycle.
    always_ff @(posedge clk) begin
        if (rst && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed self-checking bench for data_memory_unit: scalar access, vector
// load/store timing, request priority, held requests and mid-transfer reset.
`timescale 1ns/100ps
module tb_data_memory_unit;

    logic           clk;
    logic           rst;
    logic           MemWrite_scalar;
    logic [23:0]    A_scalar;
    logic [23:0]    WD_scalar;
    logic [23:0]    RD_scalar;
    logic           MemRead_vector;
    logic           MemWrite_vector;
    logic [23:0]    A_vector;
    logic [255:0]   WD_vector;
    logic [255:0]   RD_vector;
    logic           MemStall;
    logic           vDone;

    int n_cmp = 0;
    int n_err = 0;

    data_memory_unit #(.N(24), .DEPTH(256)) dut (
        .clk             (clk),
        .rst             (rst),
        .MemWrite_scalar (MemWrite_scalar),
        .A_scalar        (A_scalar),
        .WD_scalar       (WD_scalar),
        .RD_scalar       (RD_scalar),
        .MemRead_vector  (MemRead_vector),
        .MemWrite_vector (MemWrite_vector),
        .A_vector        (A_vector),
        .WD_vector       (WD_vector),
        .RD_vector       (RD_vector),
        .MemStall        (MemStall),
        .vDone           (vDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic sstore(input logic [23:0] addr, input logic [23:0] data);
        MemWrite_scalar = 1'b1;
        A_scalar        = addr;
        WD_scalar       = data;
        sync();
        MemWrite_scalar = 1'b0;
    endtask

    task automatic sread(input string tag, input logic [23:0] addr, input logic [23:0] exp);
        A_scalar = addr;
        @(negedge clk);
        check(tag, {232'd0, RD_scalar}, {232'd0, exp});
    endtask

    // Applies a vector request (caller is just past a rising edge) and watches ncyc cycles.
    task automatic vec_run(input logic rd, input logic wr, input logic [23:0] addr,
                           input logic [255:0] wd, input int hold, input int ncyc,
                           output int stalls, output int dones, output int done_idx,
                           output logic [23:0] rs8);
        MemRead_vector  = rd;
        MemWrite_vector = wr;
        A_vector        = addr;
        WD_vector       = wd;
        stalls   = 0;
        dones    = 0;
        done_idx = -1;
        rs8      = 24'd0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (MemStall) stalls++;
            if (vDone) begin
                dones++;
                done_idx = c;
            end
            if (c == 8) rs8 = RD_scalar;
            sync();
            if (c + 1 == hold) begin
                MemRead_vector  = 1'b0;
                MemWrite_vector = 1'b0;
            end
        end
    endtask

    initial begin
        int st;
        int dn;
        int di;
        logic [23:0]  rs8;
        logic [255:0] exp_load;
        logic [255:0] wd_a;
        logic [255:0] wd_c;
        logic [255:0] wd_b;

        rst = 1'b0;
        MemWrite_scalar = 1'b0;
        A_scalar = 24'd0;
        WD_scalar = 24'd0;
        MemRead_vector = 1'b0;
        MemWrite_vector = 1'b0;
        A_vector = 24'd0;
        WD_vector = 256'd0;
        for (int k = 0; k < 8; k++) begin
            exp_load[32*k +: 32] = 32'h0000_1000 + k;
            wd_a[32*k +: 32]     = 32'h0000_00A0 + k;
            wd_c[32*k +: 32]     = 32'h0000_00C0 + k;
            wd_b[32*k +: 32]     = 32'h0000_00B0 + k;
        end

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {255'd0, MemStall}, 256'd0);
        check("reset_vdone", {255'd0, vDone}, 256'd0);
        check("reset_rdvec", RD_vector, 256'd0);
        rst = 1'b1;
        sync();

        // scalar store / combinational load
        sstore(24'd6, 24'h0ABCDE);
        sstore(24'd5, 24'h123456);
        A_scalar = 24'd6;
        #1;
        check("scalar_rd6", {232'd0, RD_scalar}, {232'd0, 24'h0ABCDE});
        A_scalar = 24'd5;
        #1;
        check("scalar_rd5_same_cycle", {232'd0, RD_scalar}, {232'd0, 24'h123456});
        check("scalar_upper_zero", {248'd0, dut.r_mem[5][31:24]}, 256'd0);
        sread("scalar_wrap_261", 24'd261, 24'h123456);

        // vector load from unaligned address 19 -> base 16
        for (int k = 0; k < 8; k++) sstore(24'd16 + k[23:0], 24'h001000 + k[23:0]);
        sstore(24'd7, 24'h0BEEF7);
        sync();
        vec_run(1'b1, 1'b0, 24'd19, 256'd0, 1, 12, st, dn, di, rs8);
        check("vload_stalls", st, 256'd9);
        check("vload_dones", dn, 256'd1);
        check("vload_done_cycle", di, 256'd9);
        check("vload_data", RD_vector, exp_load);

        // vector store at base 8
        vec_run(1'b0, 1'b1, 24'd8, wd_a, 1, 12, st, dn, di, rs8);
        check("vstore_stalls", st, 256'd9);
        check("vstore_dones", dn, 256'd1);
        for (int k = 0; k < 8; k++) sread("vstore_word", 24'd8 + k[23:0], 24'h0000A0 + k[23:0]);
        sread("vstore_word7_kept", 24'd7, 24'h0BEEF7);
        sread("vstore_word16_kept", 24'd16, 24'h001000);
        check("vstore_rdvec_kept", RD_vector, exp_load);

        // both requests high -> store; scalar store held off until DONE
        sstore(24'd40, 24'h000111);
        sync();
        MemWrite_scalar = 1'b1;
        A_scalar        = 24'd40;
        WD_scalar       = 24'h000777;
        vec_run(1'b1, 1'b1, 24'd24, wd_c, 1, 12, st, dn, di, rs8);
        MemWrite_scalar = 1'b0;
        check("both_stalls", st, 256'd9);
        check("scalar_held_off", {232'd0, rs8}, {232'd0, 24'h000111});
        check("both_rdvec_kept", RD_vector, exp_load);
        sread("scalar_commit_done", 24'd40, 24'h000777);
        sread("both_word24", 24'd24, 24'h0000C0);
        sread("both_word31", 24'd31, 24'h0000C7);

        // request held through DONE, then immediate restart
        sync();
        vec_run(1'b1, 1'b0, 24'd16, 256'd0, 12, 11, st, dn, di, rs8);
        check("hold_stalls", st, 256'd10);
        check("hold_dones", dn, 256'd1);
        check("hold_done_cycle", di, 256'd9);
        vec_run(1'b0, 1'b0, 24'd0, 256'd0, 1, 10, st, dn, di, rs8);
        check("restart_stalls", st, 256'd8);
        check("restart_dones", dn, 256'd1);
        check("restart_done_cycle", di, 256'd8);
        check("restart_data", RD_vector, exp_load);

        // reset in the middle of a vector store at base 0
        for (int k = 0; k < 8; k++) sstore(k[23:0], 24'h000050 + k[23:0]);
        MemWrite_vector = 1'b1;
        A_vector        = 24'd0;
        WD_vector       = wd_b;
        sync();
        MemWrite_vector = 1'b0;
        repeat (3) sync();
        check("midreset_pre_stall", {255'd0, MemStall}, {255'd0, 1'b1});
        rst = 1'b0;
        sync();
        check("midreset_stall", {255'd0, MemStall}, 256'd0);
        check("midreset_vdone", {255'd0, vDone}, 256'd0);
        check("midreset_rdvec", RD_vector, 256'd0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) sread("midreset_written", k[23:0], 24'h0000B0 + k[23:0]);
        for (int k = 3; k < 8; k++) sread("midreset_untouched", k[23:0], 24'h000050 + k[23:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
